muller_c_seq: RTL and testbench
===============================

Name: muller_c_seq

Overview:
- Clocked 4-phase sequencer that exercises an N-input Muller C-element join in the async test area.
- Raises the C-element inputs one at a time with a programmable stagger, then waits for the synchronized output to rise.
- Lowers the inputs the same way, then waits for the output to fall.
- Flags early transitions (hysteresis violations) and timeouts, and measures rise latency for the management core.

Parameters:
- N, 6, number of C-element inputs driven.
- DLY_W, 8, width of the stagger-delay field.
- TO_W, 16, width of the timeout field and latency counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE, starts one full rise/fall transaction.
- stagger  input  DLY_W  idle cycles between successive input-bit changes.
- timeout  input  TO_W  max wait cycles in WAIT_HI/WAIT_LO; 0 = no timeout.
- c_out  input  1  asynchronous C-element output; synchronized internally by 2 flops.
- c_in  output  N  registered drive to the C-element inputs.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err_timeout  output  1  sticky; set on timeout, cleared when the next transaction is accepted.
- err_early  output  1  sticky; set on early output transition, cleared when the next transaction is accepted.
- rise_cycles  output  TO_W  cycles from last bit raised to synced c_out=1; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, FSM=IDLE, synchronizer flops 0, counters 0.
  - c_in clears immediately, even mid-transaction.
- Synchronizer: c_out_s = c_out delayed 2 clk. All checks use c_out_s only.
- States: IDLE, RISE, WAIT_HI, FALL, WAIT_LO, DONE, ERR.
- IDLE:
  - start=1 → RISE, bit index idx=0, delay counter=0.
  - Clear err_timeout, err_early and rise_cycles in the same cycle.
- RISE:
  - Set c_in[idx]. Then wait `stagger` cycles and advance idx.
  - stagger=0: all N bits are set in the single cycle of RISE entry.
  - When bit N-1 is set → WAIT_HI, rise counter=0.
  - c_out_s=1 while any c_in bit is still 0 → set err_early → ERR.
- WAIT_HI:
  - rise counter increments each cycle.
  - c_out_s=1 → latch rise_cycles = counter, then → FALL with idx=0.
  - timeout≠0 and counter==timeout before c_out_s=1 → set err_timeout → ERR.
- FALL: mirror of RISE, clearing bits.
  - c_out_s=0 while any c_in bit is still 1 → err_early → ERR.
  - After the last bit clears → WAIT_LO.
- WAIT_LO:
  - c_out_s=0 → DONE.
  - Timeout rule as in WAIT_HI.
- DONE: done=1 for exactly one cycle → IDLE.
- ERR:
  - c_in forced to 0 on entry; remain one cycle → IDLE.
  - Error flags persist until the next transaction starts.
- Ordering and sampling:
  - start is ignored while busy.
  - stagger and timeout are sampled at transaction start and held internally.
  - If start is held high, transactions run back-to-back with one IDLE cycle between them.
- Counter saturation:
  - rise_cycles saturates at 2^TO_W-1.
  - When timeout=0, the internal counter also saturates and never wraps.

Optional Feature:
- Macro: MULLER_C_SEQ_ROTATE_EN.
- Defined:
  - A rotation register rot (0..N-1, reset 0) sets the first bit index for both RISE and FALL. Order is rot, rot+1, …, wrapping mod N.
  - rot increments mod N after each DONE; it is unchanged on ERR.
  - The last-bit condition is "all bits set/cleared", not idx==N-1.
- Not defined: order is always 0..N-1; no rot register exists.

Test Plan:
- Ideal C-element model (N=6), stagger=2, timeout=100, start pulse:
  - c_in rises 1,3,7,…,63 at 3-cycle spacing.
  - rise_cycles = model delay + 2.
  - Falls in the same order; done pulses once.
  - busy is low afterwards and both error flags are 0.
- stagger=0:
  - c_in goes 0→63 in one cycle, later 63→0 in one cycle.
  - done asserts; no errors.
- Broken model with out = OR of inputs:
  - err_early=1 within 3 cycles of the first bit rising.
  - c_in=0, FSM returns to IDLE, done never pulses.
- Model output stuck at 0, timeout=10:
  - err_timeout=1 after 10 WAIT_HI cycles; c_in=0.
  - The next start clears the flag.
- rst_n asserted mid-RISE (c_in=7):
  - c_in=0 asynchronously, before the next clk edge.
  - After release, FSM is in IDLE with all outputs 0.
- With MULLER_C_SEQ_ROTATE_EN, three transactions:
  - Second transaction raises bit 1 first; third raises bit 2 first.
  - Every transaction ends with done.

Source files
------------

// File: rtl/muller_c_seq.sv
// muller_c_seq: clocked 4-phase rise/fall sequencer driving an N-input Muller C-element join.
// Optional macro MULLER_C_SEQ_ROTATE_EN rotates the first driven bit after each completed transaction.
module muller_c_seq #(
    parameter int N     = 6,
    parameter int DLY_W = 8,
    parameter int TO_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DLY_W-1:0] stagger,
    input  logic [TO_W-1:0]  timeout,
    input  logic             c_out,
    output logic [N-1:0]     c_in,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_early,
    output logic [TO_W-1:0]  rise_cycles
);
    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]     CIN_ONES = {N{1'b1}};
    localparam logic [N-1:0]     CIN_ZERO = {N{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONES  = {TO_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_WAIT_HI = 3'd2,
        S_FALL    = 3'd3,
        S_WAIT_LO = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] stg_q, stg_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     c_in_q, c_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_to_q, err_to_d;
    logic             err_early_q, err_early_d;
    logic [TO_W-1:0]  rise_q, rise_d;
    logic             sync1_q, sync2_q;
    logic             c_out_s;
    logic [N-1:0]     bit_s;
    logic [IDX_W-1:0] first_idx_s;
    logic             last_set_s;
    logic             last_clr_s;
    logic             to_hit_s;

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        sat_inc = (v == TO_ONES) ? v : v + TO_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] v);
        idx_wrap_inc = (v == IDX_LAST) ? IDX_ZERO : v + IDX_W'(1);
    endfunction

    assign c_out_s  = sync2_q;
    assign bit_s    = N'(1'b1) << idx_q;
    assign to_hit_s = (to_q != TO_ZERO) && (cnt_q == to_q);

`ifdef MULLER_C_SEQ_ROTATE_EN
    logic [IDX_W-1:0] rot_q, rot_d;
    // Start position only moves after a clean completion, so a failing pattern repeats.
    assign first_idx_s = rot_q;
    assign last_set_s  = ((c_in_q | bit_s) == CIN_ONES);
    assign last_clr_s  = ((c_in_q & ~bit_s) == CIN_ZERO);

    // Rotation register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= IDX_ZERO;
        end else begin
            rot_q <= rot_d;
        end
    end
`else
    assign first_idx_s = IDX_ZERO;
    assign last_set_s  = (idx_q == IDX_LAST);
    assign last_clr_s  = (idx_q == IDX_LAST);
`endif

    // Next-state, drive pattern and status flag computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        stg_d       = stg_q;
        to_d        = to_q;
        cnt_d       = cnt_q;
        c_in_d      = c_in_q;
        err_to_d    = err_to_q;
        err_early_d = err_early_q;
        rise_d      = rise_q;
`ifdef MULLER_C_SEQ_ROTATE_EN
        rot_d       = rot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RISE;
                    idx_d       = first_idx_s;
                    dly_d       = DLY_ZERO;
                    stg_d       = stagger;
                    to_d        = timeout;
                    err_to_d    = 1'b0;
                    err_early_d = 1'b0;
                    rise_d      = TO_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RISE: begin
                if (c_out_s) begin
                    err_early_d = 1'b1;
                    c_in_d      = CIN_ZERO;
                    state_d     = S_ERR;
                end else if (dly_q != DLY_ZERO) begin
                    dly_d = dly_q - DLY_W'(1);
                end else if (stg_q == DLY_ZERO) begin
                    c_in_d  = CIN_ONES;
                    cnt_d   = TO_ZERO;
                    state_d = S_WAIT_HI;
                end else if (last_set_s) begin
                    c_in_d  = c_in_q | bit_s;
                    cnt_d   = TO_ZERO;
                    state_d = S_WAIT_HI;
                end else begin
                    c_in_d = c_in_q | bit_s;
                    idx_d  = idx_wrap_inc(idx_q);
                    dly_d  = stg_q;
                end
            end
            S_WAIT_HI: begin
                if (c_out_s) begin
                    rise_d  = cnt_q;
                    idx_d   = first_idx_s;
                    dly_d   = DLY_ZERO;
                    state_d = S_FALL;
                end else if (to_hit_s) begin
                    err_to_d = 1'b1;
                    c_in_d   = CIN_ZERO;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_FALL: begin
                if (!c_out_s) begin
                    err_early_d = 1'b1;
                    c_in_d      = CIN_ZERO;
                    state_d     = S_ERR;
                end else if (dly_q != DLY_ZERO) begin
                    dly_d = dly_q - DLY_W'(1);
                end else if (stg_q == DLY_ZERO) begin
                    c_in_d  = CIN_ZERO;
                    cnt_d   = TO_ZERO;
                    state_d = S_WAIT_LO;
                end else if (last_clr_s) begin
                    c_in_d  = c_in_q & ~bit_s;
                    cnt_d   = TO_ZERO;
                    state_d = S_WAIT_LO;
                end else begin
                    c_in_d = c_in_q & ~bit_s;
                    idx_d  = idx_wrap_inc(idx_q);
                    dly_d  = stg_q;
                end
            end
            S_WAIT_LO: begin
                if (!c_out_s) begin
                    state_d = S_DONE;
                end else if (to_hit_s) begin
                    err_to_d = 1'b1;
                    c_in_d   = CIN_ZERO;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef MULLER_C_SEQ_ROTATE_EN
                rot_d   = idx_wrap_inc(rot_q);
`endif
            end
            S_ERR: begin
                c_in_d  = CIN_ZERO;
                state_d = S_IDLE;
            end
            default: begin
                c_in_d  = CIN_ZERO;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; c_out passes a 2-flop synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= IDX_ZERO;
            dly_q       <= DLY_ZERO;
            stg_q       <= DLY_ZERO;
            to_q        <= TO_ZERO;
            cnt_q       <= TO_ZERO;
            c_in_q      <= CIN_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_early_q <= 1'b0;
            rise_q      <= TO_ZERO;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            stg_q       <= stg_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
            c_in_q      <= c_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
            err_early_q <= err_early_d;
            rise_q      <= rise_d;
            sync1_q     <= c_out;
            sync2_q     <= sync1_q;
        end
    end

    assign c_in        = c_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_early   = err_early_q;
    assign rise_cycles = rise_q;

endmodule

// File: tb/tb_muller_c_seq.sv
// Scoreboard bench for muller_c_seq: a behavioural C-element environment, a spec-level
// expectation model feeding a queue, and a monitor that checks each finished transaction.
module tb_muller_c_seq;
    localparam int N = 6;
    localparam int M_IDEAL = 0;
    localparam int M_OR    = 1;
    localparam int M_STUCK = 2;

    typedef struct packed {
        logic        done;
        logic        early;
        logic        tout;
        logic        exact;
        logic [15:0] rise;
        logic [7:0]  len;
        logic [7:0]  gap;
        logic [15:0] to_lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   stagger;
    logic [15:0]  timeout;
    logic         c_out;
    logic [N-1:0] c_in;
    logic         busy;
    logic         done;
    logic         err_timeout;
    logic         err_early;
    logic [15:0]  rise_cycles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int env_mode = M_IDEAL;
    int env_d = 0;
    int rot_m = 0;
    logic mon_en = 1'b0;

    exp_t         exp_q[$];
    logic [N-1:0] seq_q[$];

    logic         c_hold = 1'b0;
    logic [7:0]   dline = 8'd0;
    logic         c_elem;

    muller_c_seq #(.N(N), .DLY_W(8), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stagger(stagger), .timeout(timeout),
        .c_out(c_out), .c_in(c_in), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_early(err_early), .rise_cycles(rise_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc = cyc + 1;

    // Ideal C-element: output 1 when all inputs high, 0 when all low, otherwise hold.
    always_comb c_elem = (&c_in) ? 1'b1 : ((|c_in) ? c_hold : 1'b0);

    initial forever @(posedge clk) begin
        c_hold <= c_elem;
        dline  <= {dline[6:0], c_elem};
    end

    always_comb begin
        if (env_mode == M_OR) c_out = |c_in;
        else if (env_mode == M_STUCK) c_out = 1'b0;
        else if (env_d == 0) c_out = c_elem;
        else c_out = dline[env_d-1];
    end

    task automatic chk(input string name, input longint act, input longint expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected outcome from the rules: bit order, cumulative drive values, latencies.
    task automatic push_exp(input int m, input int s, input int t, input int d);
        exp_t e;
        logic [N-1:0] v;
        int ord;
        e = '0;
        v = '0;
        if (m == M_IDEAL || (m == M_OR && s == 0)) begin
            e.done = 1'b1;
            e.rise = 16'((m == M_OR) ? 2 : d + 2);
            e.exact = 1'b1;
            if (s == 0) begin
                seq_q.push_back({N{1'b1}});
                seq_q.push_back({N{1'b0}});
                e.len = 8'd2;
            end else begin
                for (int k = 0; k < N; k++) begin
                    ord = (rot_m + k) % N;
                    v[ord] = 1'b1;
                    seq_q.push_back(v);
                end
                for (int k = 0; k < N; k++) begin
                    ord = (rot_m + k) % N;
                    v[ord] = 1'b0;
                    seq_q.push_back(v);
                end
                e.len = 8'(2 * N);
                e.gap = 8'(s + 1);
            end
`ifdef MULLER_C_SEQ_ROTATE_EN
            rot_m = (rot_m + 1) % N;
`endif
        end else if (m == M_OR) begin
            e.early = 1'b1;
            e.len = 8'd1;
            v[rot_m] = 1'b1;
            seq_q.push_back(v);
        end else begin
            e.tout = 1'b1;
            e.exact = 1'b1;
            e.to_lat = 16'(t + 1);
            if (s == 0) begin
                seq_q.push_back({N{1'b1}});
                e.len = 8'd2;
            end else begin
                for (int k = 0; k < N; k++) begin
                    ord = (rot_m + k) % N;
                    v[ord] = 1'b1;
                    seq_q.push_back(v);
                end
                e.len = 8'(N + 1);
                e.gap = 8'(s + 1);
            end
            seq_q.push_back({N{1'b0}});
        end
        exp_q.push_back(e);
    endtask

    // Monitor state
    logic         act = 1'b0;
    logic [N-1:0] prev_cin = '0;
    logic [N-1:0] rec_v[0:31];
    int           rec_t[0:31];
    int           nrec, ndone, t_first, t_full, t_err, t_to, bad, gbad, lim;
    exp_t         me;
    logic [N-1:0] sv;

    initial forever @(negedge clk) begin
        if (mon_en) begin
            if (busy && !act) begin
                act = 1'b1;
                nrec = 0; ndone = 0;
                t_first = -1; t_full = -1; t_err = -1; t_to = -1;
                chk("clr_flags", {err_early, err_timeout}, 0);
                chk("clr_rise", rise_cycles, 0);
            end
            if (act) begin
                if (c_in != prev_cin && nrec < 32) begin
                    rec_v[nrec] = c_in;
                    rec_t[nrec] = cyc;
                    nrec = nrec + 1;
                end
                if (c_in != '0 && t_first < 0) t_first = cyc;
                if (&c_in && t_full < 0) t_full = cyc;
                if (err_early && t_err < 0) t_err = cyc;
                if (err_timeout && t_to < 0) t_to = cyc;
                if (done) ndone = ndone + 1;
                if (!busy) begin
                    act = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", 1, 0);
                    end else begin
                        me = exp_q.pop_front();
                        chk("done_cnt", ndone, me.done);
                        chk("err_early", err_early, me.early);
                        chk("err_timeout", err_timeout, me.tout);
                        chk("rise_cycles", rise_cycles, me.rise);
                        chk("cin_idle", c_in, 0);
                        bad = 0;
                        for (int k = 0; k < int'(me.len); k++) begin
                            sv = seq_q.pop_front();
                            if (k >= nrec || rec_v[k] != sv) bad = bad + 1;
                        end
                        chk("seq_vals", bad, 0);
                        if (me.exact) chk("seq_len", nrec, me.len);
                        if (me.gap != 0) begin
                            gbad = 0;
                            lim = (nrec < 2 * N) ? nrec : 2 * N;
                            for (int i = 1; i < lim; i++)
                                if (i != N && rec_t[i] - rec_t[i-1] != int'(me.gap)) gbad = gbad + 1;
                            chk("gap", gbad, 0);
                        end
                        if (me.early)
                            chk("early_lat", (t_first >= 0 && t_err >= t_first + 1 && t_err <= t_first + 3), 1);
                        if (me.tout) chk("to_lat", t_to - t_full, me.to_lat);
                    end
                end
            end
        end
        prev_cin = c_in;
    end

    task automatic wait_txn_end(input int budget);
        int n;
        n = 0;
        while (!busy && n < 4) begin @(negedge clk); n++; end
        if (!busy) chk("busy_rise", 0, 1);
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        if (busy) chk("txn_timeout", 1, 0);
    endtask

    task automatic run_txn(input int m, input int s, input int t, input int d);
        @(negedge clk);
        env_mode = m; env_d = d;
        stagger = 8'(s); timeout = 16'(t);
        push_exp(m, s, t, d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stagger = 8'($urandom);
        timeout = 16'($urandom);
        wait_txn_end(3000);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int m, s, t, d, r, n;
        rst_n = 1'b0; start = 1'b0; stagger = 8'd0; timeout = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_cin", c_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_early, err_timeout}, 0);
        chk("rst_rise", rise_cycles, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(M_IDEAL, 2, 100, 3);
        run_txn(M_IDEAL, 0, 100, 1);
        run_txn(M_OR, 2, 50, 0);
        chk("early_sticky", err_early, 1);
        chk("early_cin", c_in, 0);
        run_txn(M_STUCK, 2, 10, 0);
        chk("to_sticky", err_timeout, 1);
        chk("to_cin", c_in, 0);
        run_txn(M_IDEAL, 1, 0, 2);
        chk("to_cleared", err_timeout, 0);

        // start held high: two transactions with a single idle cycle between
        @(negedge clk);
        env_mode = M_IDEAL; env_d = 1; stagger = 8'd1; timeout = 16'd0;
        push_exp(M_IDEAL, 1, 0, 1);
        push_exp(M_IDEAL, 1, 0, 1);
        start = 1'b1;
        wait_txn_end(3000);
        chk("b2b_idle", busy, 0);
        @(negedge clk);
        chk("b2b_restart", busy, 1);
        start = 1'b0;
        wait_txn_end(3000);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            s = $urandom_range(0, 4);
            d = $urandom_range(0, 5);
            if (r < 6) begin
                m = M_IDEAL;
                t = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(d + 3, d + 60);
            end else if (r < 8) begin
                m = M_OR; d = 0;
                t = ($urandom_range(0, 1) == 0) ? 0 : 40;
            end else begin
                m = M_STUCK;
                t = $urandom_range(1, 20);
            end
            run_txn(m, s, t, d);
        end

        // asynchronous reset in the middle of the rise phase
        mon_en = 1'b0;
        @(negedge clk);
        env_mode = M_IDEAL; env_d = 0; stagger = 8'd3; timeout = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ($countones(c_in) != 3 && n < 100) begin @(negedge clk); n++; end
        chk("mid_rise_3bits", $countones(c_in), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cin", c_in, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_outs", {c_in, done, err_early, err_timeout}, 0);
        chk("post_rst_rise", rise_cycles, 0);
        rot_m = 0;
        act = 1'b0;
        prev_cin = c_in;
        repeat (12) @(negedge clk);
        mon_en = 1'b1;
        run_txn(M_IDEAL, 2, 0, 2);

        chk("exp_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
